// File: rtl/reg_file_wb.sv
// Architectural register file with write-back bypass and per-register pending-write scoreboard.
// Operands registered (1 cycle); stall_o is combinational and holds both operand capture and issue.
module reg_file_wb #(
  parameter int NREGS  = 32,
  parameter int XLEN   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            rd_en_i,
  output logic [XLEN-1:0] reg1_data_o,
  output logic [XLEN-1:0] reg2_data_o,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            w_valid_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [XLEN-1:0] w_data_i,
  input  logic            flush_i,
  output logic            stall_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] cnt_q  [NREGS];
  logic [PEND_W-1:0] cnt_d  [NREGS];
  logic [XLEN-1:0]   reg1_q, reg1_d;
  logic [XLEN-1:0]   reg2_q, reg2_d;
  logic [XLEN-1:0]   rd1_val, rd2_val;
  logic              land1, land2, haz1, haz2, full, stall;
  logic              issue_eff, w_eff;

  // A pending write that lands this very cycle is covered by the bypass, so it does not stall.
  always_comb begin
    land1 = w_valid_i && (w_addr_i == rs1_addr_i) && (cnt_q[rs1_addr_i] == CNT_ONE);
    land2 = w_valid_i && (w_addr_i == rs2_addr_i) && (cnt_q[rs2_addr_i] == CNT_ONE);
    haz1  = rs1_used_i && (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0) && !land1;
    haz2  = rs2_used_i && (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0) && !land2;
    full  = issue_valid_i && (issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX);
    stall = haz1 || haz2 || full;
    issue_eff = issue_valid_i && !stall && (issue_rd_i != '0);
    w_eff     = w_valid_i && (w_addr_i != '0);
  end

  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs1_addr_i != '0) rd1_val = (w_eff && (w_addr_i == rs1_addr_i)) ? w_data_i : regs_q[rs1_addr_i];
    if (rs2_addr_i != '0) rd2_val = (w_eff && (w_addr_i == rs2_addr_i)) ? w_data_i : regs_q[rs2_addr_i];
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    if (rd_en_i && !stall) begin
      reg1_d = rd1_val;
      reg2_d = rd2_val;
    end
  end

  // Write-back to a register with no pending count leaves it at zero rather than wrapping.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (issue_eff && (issue_rd_i == AW'(r))) begin
        if (!(w_valid_i && (w_addr_i == AW'(r)) && (cnt_q[r] != '0)))
          cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (w_valid_i && (w_addr_i == AW'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      reg1_q <= '0;
      reg2_q <= '0;
    end else begin
      if (w_eff) regs_q[w_addr_i] <= w_data_i;
      cnt_q  <= cnt_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
    end
  end

  assign reg1_data_o = reg1_q;
  assign reg2_data_o = reg2_q;
  assign stall_o     = stall;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: vector table for read/write/bypass/hazard, hand sequences for scoreboard, flush and reset.
module tb_reg_file_wb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, w_addr_i;
  logic        rs1_used_i, rs2_used_i, rd_en_i, issue_valid_i, w_valid_i, flush_i;
  logic [31:0] w_data_i, reg1_data_o, reg2_data_o;
  logic        stall_o;

  int n_vec  = 0;
  int n_fail = 0;

  reg_file_wb #(.NREGS(32), .XLEN(32), .PEND_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_en_i(rd_en_i), .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .flush_i(flush_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, rd_en, iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_r1, e_r2;
  } vec_t;

  function automatic vec_t mkv(input logic [4:0] rs1, rs2, input logic u1, u2, rd_en, iv,
                               input logic [4:0] ird, input logic wv, input logic [4:0] wa,
                               input logic [31:0] wd, input logic fl, input logic es,
                               input logic [31:0] e1, e2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd_en = rd_en; v.iv = iv;
    v.ird = ird; v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl;
    v.e_stall = es; v.e_r1 = e1; v.e_r2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rs1_addr_i = '0; rs2_addr_i = '0; rs1_used_i = 0; rs2_used_i = 0; rd_en_i = 0;
    issue_valid_i = 0; issue_rd_i = '0; w_valid_i = 0; w_addr_i = '0; w_data_i = '0; flush_i = 0;
  endtask

  vec_t vt [14];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mkv(5, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    vt[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,         32'h0);
    vt[2]  = mkv(5, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'h0);
    vt[3]  = mkv(5, 0, 0, 0, 1, 0, 0, 1, 0, 32'h1234,      0, 0, 32'hDEAD_BEEF, 32'h0);
    vt[4]  = mkv(0, 5, 0, 0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF);
    vt[5]  = mkv(7, 5, 0, 0, 1, 0, 0, 1, 7, 32'hA5A5_0001, 0, 0, 32'hA5A5_0001, 32'hDEAD_BEEF);
    vt[6]  = mkv(0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0,         0, 0, 32'hA5A5_0001, 32'hDEAD_BEEF);
    vt[7]  = mkv(3, 5, 1, 0, 1, 0, 0, 0, 0, 32'h0,         0, 1, 32'hA5A5_0001, 32'hDEAD_BEEF);
    vt[8]  = mkv(3, 5, 1, 0, 1, 0, 0, 1, 3, 32'h55,        0, 0, 32'h55,        32'hDEAD_BEEF);
    vt[9]  = mkv(3, 7, 1, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h55,        32'hA5A5_0001);
    vt[10] = mkv(0, 0, 0, 0, 0, 1, 6, 0, 0, 32'h0,         0, 0, 32'h55,        32'hA5A5_0001);
    vt[11] = mkv(3, 6, 0, 1, 1, 0, 0, 0, 0, 32'h0,         0, 1, 32'h55,        32'hA5A5_0001);
    vt[12] = mkv(3, 6, 0, 0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h55,        32'h0);
    vt[13] = mkv(0, 6, 1, 1, 1, 0, 0, 1, 6, 32'h66,        0, 0, 32'h0,         32'h66);

    idle();
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset_reg1", reg1_data_o, 32'h0);
    chk("reset_reg2", reg2_data_o, 32'h0);
    chk("reset_stall", {31'b0, stall_o}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      rs1_addr_i = vt[i].rs1; rs2_addr_i = vt[i].rs2;
      rs1_used_i = vt[i].u1;  rs2_used_i = vt[i].u2; rd_en_i = vt[i].rd_en;
      issue_valid_i = vt[i].iv; issue_rd_i = vt[i].ird;
      w_valid_i = vt[i].wv; w_addr_i = vt[i].wa; w_data_i = vt[i].wd; flush_i = vt[i].fl;
      #1 chk($sformatf("vec%0d_stall", i), {31'b0, stall_o}, {31'b0, vt[i].e_stall});
      tick();
      chk($sformatf("vec%0d_reg1", i), reg1_data_o, vt[i].e_r1);
      chk($sformatf("vec%0d_reg2", i), reg2_data_o, vt[i].e_r2);
    end
    idle();

    // Scoreboard saturation on x9
    for (int k = 0; k < 3; k++) begin
      issue_valid_i = 1; issue_rd_i = 5'd9;
      #1 chk($sformatf("issue9_%0d", k), {31'b0, stall_o}, 32'h0);
      tick();
    end
    #1 chk("full9", {31'b0, stall_o}, 32'h1);
    tick();
    chk("full9_hold", {31'b0, stall_o}, 32'h1);
    issue_valid_i = 0; w_valid_i = 1; w_addr_i = 5'd9; w_data_i = 32'h9;
    #1 chk("wb9_nostall", {31'b0, stall_o}, 32'h0);
    tick();
    idle();
    issue_valid_i = 1; issue_rd_i = 5'd9;
    #1 chk("cnt2_not_full", {31'b0, stall_o}, 32'h0);
    w_valid_i = 1; w_addr_i = 5'd9;
    #1 chk("iss_wb9_nostall", {31'b0, stall_o}, 32'h0);
    tick();
    idle();
    issue_valid_i = 1; issue_rd_i = 5'd9;
    #1 chk("cnt2_kept", {31'b0, stall_o}, 32'h0);
    tick();
    #1 chk("full9_again", {31'b0, stall_o}, 32'h1);
    idle();
    rs1_addr_i = 5'd9; rs1_used_i = 1; w_valid_i = 1; w_addr_i = 5'd9;
    #1 chk("haz9_cnt3_wb", {31'b0, stall_o}, 32'h1);
    tick();
    idle(); w_valid_i = 1; w_addr_i = 5'd9;
    tick();
    rs1_addr_i = 5'd9; rs1_used_i = 1;
    #1 chk("haz9_last_lands", {31'b0, stall_o}, 32'h0);
    tick();
    idle(); rs1_addr_i = 5'd9; rs1_used_i = 1;
    #1 chk("haz9_drained", {31'b0, stall_o}, 32'h0);
    idle(); w_valid_i = 1; w_addr_i = 5'd9; w_data_i = 32'h99;
    tick();
    idle(); issue_valid_i = 1; issue_rd_i = 5'd9;
    #1 chk("no_underflow", {31'b0, stall_o}, 32'h0);
    idle();
    rd_en_i = 1; rs1_addr_i = 5'd9;
    tick();
    chk("x9_written", reg1_data_o, 32'h99);
    idle();

    // Flush with pending x4, same-cycle issue x10 and write x11
    for (int k = 0; k < 2; k++) begin
      issue_valid_i = 1; issue_rd_i = 5'd4;
      tick();
    end
    idle(); rs2_addr_i = 5'd4; rs2_used_i = 1;
    #1 chk("haz4_pending", {31'b0, stall_o}, 32'h1);
    idle();
    flush_i = 1; issue_valid_i = 1; issue_rd_i = 5'd10;
    w_valid_i = 1; w_addr_i = 5'd11; w_data_i = 32'hBB;
    tick();
    idle(); rs2_addr_i = 5'd4; rs2_used_i = 1;
    #1 chk("flush_clears4", {31'b0, stall_o}, 32'h0);
    rs1_addr_i = 5'd10; rs1_used_i = 1;
    #1 chk("flush_drops_issue", {31'b0, stall_o}, 32'h0);
    rs1_addr_i = 5'd11; rd_en_i = 1;
    tick();
    chk("flush_write_kept", reg1_data_o, 32'hBB);
    chk("flush_rs2_read", reg2_data_o, 32'h0);
    idle();

    // Reset asserted during a write
    issue_valid_i = 1; issue_rd_i = 5'd13;
    tick();
    idle();
    w_valid_i = 1; w_addr_i = 5'd12; w_data_i = 32'hCC;
    rst_i = 1'b1;
    #1 chk("rst_async_reg1", reg1_data_o, 32'h0);
    tick();
    rst_i = 1'b0;
    idle(); rs1_addr_i = 5'd13; rs1_used_i = 1;
    #1 chk("rst_clears_cnt", {31'b0, stall_o}, 32'h0);
    rs1_addr_i = 5'd12; rs2_addr_i = 5'd5; rd_en_i = 1;
    tick();
    chk("rst_write_dropped", reg1_data_o, 32'h0);
    chk("rst_array_clear", reg2_data_o, 32'h0);
    idle();
    rs1_addr_i = 5'd12; rd_en_i = 1; w_valid_i = 1; w_addr_i = 5'd12; w_data_i = 32'hCC;
    tick();
    chk("post_rst_normal", reg1_data_o, 32'hCC);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
